// File: rtl/framebuffer_writer.sv
// Purpose : packs 7-byte point records (8 with FB_WRITER_CHECKSUM_EN) from a
//           byte stream into 64-bit framebuffer words and commits whole frames.
// Latency : BRAM write 1 cycle after a record's final byte; frame_done_out 1
//           cycle after that write, or 1 cycle after a truncated final byte.
// Backpr. : byte_ready_out is low during the WRITE and COMMIT cycles, so the
//           stream sustains at most 7 bytes per 8 cycles.
//
// Optional feature macro: FB_WRITER_CHECKSUM_EN (8th byte = XOR of bytes 0..6).
//
// Ports:
//   clock_in, reset_in (synchronous, active-low)
//   byte_in / byte_valid_in / byte_last_in / byte_ready_out : input byte stream
//   bram_addr_out / bram_data_out / bram_we_out             : framebuffer write port
//   point_count_out, frame_done_out                         : frame commit report
//   overflow_out (sticky until commit), error_out (pulse)   : status
module framebuffer_writer #(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_POINTS = 32768
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  input  logic                  byte_last_in,
  output logic                  byte_ready_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [63:0]           bram_data_out,
  output logic                  bram_we_out,
  output logic [15:0]           point_count_out,
  output logic                  frame_done_out,
  output logic                  overflow_out,
  output logic                  error_out
);

`ifdef FB_WRITER_CHECKSUM_EN
  localparam int REC_BYTES = 8;
`else
  localparam int REC_BYTES = 7;
`endif
  // One extra pointer bit so a full framebuffer (pointer == 2^ADDR_WIDTH) is representable.
  localparam int              PTR_W    = ADDR_WIDTH + 1;
  localparam logic [2:0]      LAST_IDX = 3'(REC_BYTES - 1);
  localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(MAX_POINTS);

  typedef enum logic [1:0] {COLLECT, WRITE, COMMIT} state_t;

  state_t                state, state_nxt;
  logic                  run_q;     // holds ready low for the first cycle after reset
  logic [2:0]            idx;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_sat;
  logic                  last_q;
  logic                  ovf_q;
  logic [7:0]            rec [REC_BYTES];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [63:0]           data_q;
  logic [15:0]           count_q;
  logic [15:0]           count_now;
  logic [63:0]           packed_word;
  logic                  rdy;
  logic                  accept;
  logic                  rec_ok;
  logic                  has_room;

  assign rdy         = run_q && (state == COLLECT);
  assign accept      = rdy && byte_valid_in;
  assign has_room    = ptr < MAX_PTR;
  assign packed_word = {8'h00, rec[0], rec[1], rec[2], rec[3], rec[4], rec[5], rec[6]};
  assign ptr_sat     = (ptr > MAX_PTR) ? MAX_PTR : ptr;
  assign count_now   = 16'(ptr_sat);
  assign overflow_out = ovf_q;

`ifdef FB_WRITER_CHECKSUM_EN
  assign rec_ok = (rec[0] ^ rec[1] ^ rec[2] ^ rec[3] ^ rec[4] ^ rec[5] ^ rec[6]) == rec[7];
`else
  assign rec_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clock_in) begin
    if (!reset_in) state <= COLLECT;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (accept && idx == LAST_IDX) state_nxt = WRITE;
        else if (accept && byte_last_in) state_nxt = COMMIT;  // truncated record
      end
      WRITE:   state_nxt = last_q ? COMMIT : COLLECT;
      COMMIT:  state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Record byte storage; no reset needed, every byte is rewritten before use.
  always_ff @(posedge clock_in) begin
    if (accept) rec[idx] <= byte_in;
  end

  // Datapath registers
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      run_q   <= 1'b0;
      idx     <= 3'd0;
      ptr     <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      run_q <= 1'b1;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              idx    <= 3'd0;
              last_q <= byte_last_in;
            end else if (byte_last_in) begin
              idx <= 3'd0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        WRITE: begin
          if (rec_ok) begin
            if (has_room) begin
              addr_q <= ptr[ADDR_WIDTH-1:0];
              data_q <= packed_word;
              ptr    <= ptr + PTR_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          count_q <= count_now;
          ptr     <= '0;
          idx     <= 3'd0;
          ovf_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: the write port is driven live in WRITE and holds its last write otherwise;
  // the point count is presented alongside the commit pulse and held afterwards.
  always_comb begin
    byte_ready_out  = rdy;
    bram_we_out     = 1'b0;
    bram_addr_out   = addr_q;
    bram_data_out   = data_q;
    frame_done_out  = 1'b0;
    point_count_out = count_q;
    error_out       = 1'b0;
    case (state)
      COLLECT: error_out = accept && byte_last_in && (idx != LAST_IDX);
      WRITE: begin
        if (!rec_ok) begin
          error_out = 1'b1;
        end else if (has_room) begin
          bram_we_out   = 1'b1;
          bram_addr_out = ptr[ADDR_WIDTH-1:0];
          bram_data_out = packed_word;
        end
      end
      COMMIT: begin
        frame_done_out  = 1'b1;
        point_count_out = count_now;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;

`ifdef FB_WRITER_CHECKSUM_EN
  localparam int REC = 8;
`else
  localparam int REC = 7;
`endif
  localparam int AW   = 15;
  localparam int MAXP = 4;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic [7:0]    byte_in;
  logic          byte_valid_in;
  logic          byte_last_in;
  logic          byte_ready_out;
  logic [AW-1:0] bram_addr_out;
  logic [63:0]   bram_data_out;
  logic          bram_we_out;
  logic [15:0]   point_count_out;
  logic          frame_done_out;
  logic          overflow_out;
  logic          error_out;

  framebuffer_writer #(.ADDR_WIDTH(AW), .MAX_POINTS(MAXP)) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_last_in(byte_last_in),
    .byte_ready_out(byte_ready_out),
    .bram_addr_out(bram_addr_out), .bram_data_out(bram_data_out), .bram_we_out(bram_we_out),
    .point_count_out(point_count_out), .frame_done_out(frame_done_out),
    .overflow_out(overflow_out), .error_out(error_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_cnt[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int err_seen = 0;
  int err_exp = 0;
  int ptr_model = 0;
  bit ovf_model = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Scoreboard side: compare writes and commits as the DUT produces them.
  always @(negedge clock_in) begin
    if (reset_in === 1'b1) begin
      if (bram_we_out) begin
        if (exp_wr.size() == 0) check("write_unexpected", 1, 0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("write_addr", 64'(bram_addr_out), 64'(e.addr));
          check("write_data", bram_data_out, e.data);
        end
      end
      if (frame_done_out) begin
        if (exp_cnt.size() == 0) check("commit_unexpected", 1, 0);
        else check("point_count", 64'(point_count_out), 64'(exp_cnt.pop_front()));
      end
      if (error_out) err_seen = err_seen + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int w = 0;
    byte_in = b; byte_last_in = last; byte_valid_in = 1'b1;
    while (!byte_ready_out && w < 20) begin tick(); w++; end
    check("byte_wait_cycles", 64'(w), 0);
    tick();
  endtask

  task automatic send_record(input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] b, input logic [7:0] g, input logic [7:0] r,
                             input bit last, input bit bad_ck);
    logic [7:0] bs [8];
    bit exp_we;
    bs[0] = x[15:8]; bs[1] = x[7:0]; bs[2] = y[15:8]; bs[3] = y[7:0];
    bs[4] = b; bs[5] = g; bs[6] = r;
    bs[7] = bad_ck ? 8'h00 : (bs[0] ^ bs[1] ^ bs[2] ^ bs[3] ^ bs[4] ^ bs[5] ^ bs[6]);
    exp_we = !bad_ck && (ptr_model < MAXP);
    if (exp_we) begin
      exp_wr.push_back('{addr: AW'(ptr_model), data: {8'h00, x, y, b, g, r}});
      ptr_model++;
    end else if (!bad_ck) begin
      ovf_model = 1;
    end
    if (bad_ck) err_exp++;
    if (last) exp_cnt.push_back(16'(ptr_model));
    for (int i = 0; i < REC; i++) send_byte(bs[i], last && (i == REC - 1));
    byte_valid_in = 1'b0;
    // WRITE cycle
    check("ready_in_write", 64'(byte_ready_out), 0);
    check("we_in_write", 64'(bram_we_out), 64'(exp_we));
    tick();
    check("overflow_after_write", 64'(overflow_out), 64'(ovf_model));
    if (last) begin
      check("done_after_last", 64'(frame_done_out), 1);
      tick();
      ovf_model = 0; ptr_model = 0;
      check("overflow_after_commit", 64'(overflow_out), 0);
    end else begin
      check("ready_after_write", 64'(byte_ready_out), 1);
    end
  endtask

  // Sends n bytes of a record with last on the n-th (n < REC).
  task automatic send_truncated(input int n);
    exp_cnt.push_back(16'(ptr_model));
    err_exp++;
    for (int i = 0; i < n; i++) send_byte(8'(8'hA0 + i), i == n - 1);
    byte_valid_in = 1'b0;
    check("done_after_truncated", 64'(frame_done_out), 1);
    tick();
    ovf_model = 0; ptr_model = 0;
    check("ready_after_truncated", 64'(byte_ready_out), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(byte_ready_out), 0);
    check({tag, "_we"}, 64'(bram_we_out), 0);
    check({tag, "_done"}, 64'(frame_done_out), 0);
    check({tag, "_err"}, 64'(error_out), 0);
    check({tag, "_ovf"}, 64'(overflow_out), 0);
    check({tag, "_count"}, 64'(point_count_out), 0);
    check({tag, "_addr"}, 64'(bram_addr_out), 0);
    check({tag, "_data"}, bram_data_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b0; byte_in = 8'h00; byte_valid_in = 1'b0; byte_last_in = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_init");
    reset_in = 1'b1;
    tick();
    check("ready_after_reset", 64'(byte_ready_out), 1);

    // Two records, last on the second.
    send_record(16'h1234, 16'hABCD, 8'h11, 8'h22, 8'h33, 0, 0);
    send_record(16'hFFFF, 16'h0000, 8'h01, 8'h02, 8'h03, 1, 0);
    check("count_held", 64'(point_count_out), 2);
    check("no_error_two_records", 64'(err_seen), 64'(err_exp));

    // One record, then reset mid-record held low for 3 cycles.
    send_record(16'h0101, 16'h0202, 8'h03, 8'h04, 8'h05, 0, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h5A, 1'b0);
    byte_valid_in = 1'b0;
    reset_in = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_mid");
    ptr_model = 0; ovf_model = 0;
    reset_in = 1'b1;
    tick();
    check("ready_after_reset_mid", 64'(byte_ready_out), 1);
    send_record(16'h4321, 16'h8765, 8'hAA, 8'hBB, 8'hCC, 1, 0);

    // Back-to-back stream: 3 records.
    send_record(16'h0001, 16'h0002, 8'h10, 8'h20, 8'h30, 0, 0);
    send_record(16'h0003, 16'h0004, 8'h40, 8'h50, 8'h60, 0, 0);
    send_record(16'h0005, 16'h0006, 8'h70, 8'h80, 8'h90, 1, 0);

    // Truncated second record.
    send_record(16'hBEEF, 16'hCAFE, 8'h12, 8'h34, 8'h56, 0, 0);
    send_truncated(4);
    check("error_truncated", 64'(err_seen), 64'(err_exp));
    send_record(16'h7777, 16'h8888, 8'h99, 8'h66, 8'h55, 1, 0);

    // Empty frame: last on the first byte.
    send_truncated(1);
    check("error_empty_frame", 64'(err_seen), 64'(err_exp));

    // Overflow: 6 records with MAX_POINTS=4.
    for (int i = 0; i < 6; i++)
      send_record(16'(16'h0100 + i), 16'(16'h0200 + i), 8'(i), 8'(i + 1), 8'(i + 2), i == 5, 0);
    check("count_after_overflow", 64'(point_count_out), 4);

`ifdef FB_WRITER_CHECKSUM_EN
    send_record(16'h1111, 16'h2222, 8'h33, 8'h44, 8'h55, 0, 0);
    send_record(16'h9999, 16'hAAAA, 8'hBB, 8'hCC, 8'hDD, 0, 1);
    send_record(16'h1357, 16'h2468, 8'h0A, 8'h0B, 8'h0C, 1, 0);
    check("error_checksum", 64'(err_seen), 64'(err_exp));
`endif

    repeat (3) tick();
    check("writes_outstanding", 64'(exp_wr.size()), 0);
    check("commits_outstanding", 64'(exp_cnt.size()), 0);
    check("error_total", 64'(err_seen), 64'(err_exp));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Fills the 64-bit point framebuffer that the display controller scans out to the X/Y DACs and RGB PWMs.
- Consumes a byte stream of point records arriving from the network path, using a valid/ready handshake.
- Packs each record into one framebuffer word and writes it through the BRAM write port.
- Commits a frame, reporting its point count, when the frame's last byte arrives.

Parameters:
- ADDR_WIDTH, 15: framebuffer address width.
- MAX_POINTS, 32768: maximum points stored per frame; must be ≤ 2^ADDR_WIDTH.

Ports:
- clock_in  input  1  system clock.
- reset_in  input  1  synchronous reset, active-low.
- byte_in  input  8  stream data byte.
- byte_valid_in  input  1  byte_in valid.
- byte_last_in  input  1  byte is the final byte of the frame.
- byte_ready_out  output  1  writer accepts a byte this cycle.
- bram_addr_out  output  ADDR_WIDTH  framebuffer write address.
- bram_data_out  output  64  framebuffer write word.
- bram_we_out  output  1  write strobe.
- point_count_out  output  16  complete points in the last committed frame.
- frame_done_out  output  1  one-cycle commit pulse.
- overflow_out  output  1  sticky; the current frame exceeded MAX_POINTS.
- error_out  output  1  one-cycle pulse; a truncated or bad record was dropped.

Behaviour:
- Reset (reset_in==0 at a clock edge), all outputs 0:
  - state=COLLECT, byte index=0, write pointer=0.
  - byte_ready_out, bram_we_out, frame_done_out, error_out, overflow_out all 0.
  - point_count_out=0, bram_addr_out=0, bram_data_out=0.
  - byte_ready_out rises on the first cycle after reset deasserts.
- Reset mid-record or mid-frame discards all partial state; nothing already written is rolled back.
- Handshake:
  - A byte transfers when byte_valid_in && byte_ready_out.
  - byte_ready_out=1 only in COLLECT.
- Record format, 7 bytes in order: x[15:8], x[7:0], y[15:8], y[7:0], b, g, r.
- Packed word: {8'h00, x[15:0], y[15:0], b, g, r}, i.e. x at [55:40], y at [39:24], b at [23:16], g at [15:8], r at [7:0].
- States:
  - COLLECT:
    - Store the accepted byte and increment the byte index.
    - Index-6 accept → WRITE, and record whether byte_last_in was set.
    - Accept with byte_last_in at index 0..5 → COMMIT, drop the partial record, pulse error_out.
  - WRITE (one cycle, byte_ready_out=0):
    - If pointer < MAX_POINTS: bram_we_out=1, bram_addr_out=pointer, bram_data_out=packed word; pointer+1.
    - Otherwise: no write, overflow_out←1.
    - Next state: COMMIT if last was flagged, else COLLECT with index=0.
  - COMMIT (one cycle, byte_ready_out=0):
    - frame_done_out=1.
    - point_count_out←min(pointer, MAX_POINTS), zero-extended to 16 bits.
    - pointer←0, index←0, overflow_out←0 on the following cycle.
    - → COLLECT.
- Latency:
  - Write strobe occurs exactly 1 cycle after the 7th byte's handshake.
  - frame_done_out occurs 2 cycles after the final handshake of a complete last record, or 1 cycle after a truncated one.
- Throughput: max 7 bytes per 8 cycles.
- bram_we_out is high only in WRITE. bram_addr_out/bram_data_out hold their last values otherwise.
- Empty frame (last on a truncated first record): commit with point_count_out=0.
- The pointer never wraps; excess records are dropped and overflow_out remains set until commit.
- Ordering when overflow and error coincide: the error pulse is emitted before the commit.
- byte_in and byte_last_in are ignored when no handshake occurs.

Optional Feature:
- Macro FB_WRITER_CHECKSUM_EN.
- Defined:
  - Records are 8 bytes; byte 7 is the XOR of bytes 0..6. WRITE is entered after index 7.
  - On mismatch: no write, no pointer increment, error_out pulses in the WRITE cycle; last/commit handling is unchanged.
- Undefined: 7-byte records as above, no check.

Test Plan:
- Reset held low 3 cycles mid-record, then released → all outputs 0; byte_ready_out=1 the next cycle; the following record is written to address 0.
- Two records, (x=0x1234, y=0xABCD, b=0x11, g=0x22, r=0x33) then (x=0xFFFF, y=0x0000, 0x01, 0x02, 0x03) with last on the second → two results:
  - writes at addr 0 = 0x00_1234_ABCD_112233 and addr 1 = 0x00_FFFF_0000_010203;
  - frame_done_out pulses once, point_count_out=2.
- Back-to-back valid for 21 bytes → byte_ready_out drops exactly one cycle after every 7th byte; 3 writes at addresses 0, 1, 2.
- Last asserted on the 4th byte of the second record → one write, error_out pulses, commit with point_count_out=1, next frame starts at addr 0.
- MAX_POINTS=4, send 6 records plus last → 4 writes (addr 0..3), overflow_out=1 from the 5th record until commit, point_count_out=4, overflow_out=0 after commit.
- (FB_WRITER_CHECKSUM_EN) record with bad checksum 0x00 between two good records → only the good ones are written, at addr 0 and 1; error_out pulses once.
